// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch-address generator.
//   - Default reset vector, exception handler entry and IMEM bounds.
//   - pc_state_t   : fetch sequencer states {BOOT, RUN, HOLD}.
//   - redir_kind_t : kind of a latched redirect {NONE, BR, ERET}.
//   - fetch_addr_err() : alignment / range check for a fetch address.
package cpu_pkg;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_PC   = 32'h0000_4180;
    localparam logic [31:0] DEF_IMEM_LO  = 32'h0000_3000;
    localparam logic [31:0] DEF_IMEM_HI  = 32'h0000_6FFC;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HOLD
    } pc_state_t;

    typedef enum logic [1:0] {
        NONE,
        BR,
        ERET
    } redir_kind_t;

    // Arguments are zero-extended to 64 bits by the caller so the check works
    // for any address width up to 64.
    function automatic logic fetch_addr_err(input logic [63:0] addr,
                                            input logic [63:0] lo,
                                            input logic [63:0] hi);
        return (addr[1:0] != 2'b00) || (addr < lo) || (addr > hi);
    endfunction

endpackage

// File: rtl/pc_redir_latch.sv
// Holds a redirect (branch or eret) that arrived while fetch was stalled.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset (clears the latch)
//   clear         : discard the latch on the next edge (applied or flushed)
//   capture       : store the merged redirect on the next edge
//   eret_req, epc : live eret request and its return address
//   br_taken,
//   br_target     : live branch/jump request and its target
//   merged_kind,
//   merged_target : latch contents after this cycle's requests are folded in
//                   (combinational); this is what the PC would be redirected to
//   latched_kind  : registered kind currently held
module pc_redir_latch
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              capture,
    input  logic              eret_req,
    input  logic [ADDR_W-1:0] epc,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic [1:0]        merged_kind,
    output logic [ADDR_W-1:0] merged_target,
    output logic [1:0]        latched_kind
);

    redir_kind_t       kind_q;
    redir_kind_t       kind_n;
    logic [ADDR_W-1:0] tgt_q;
    logic [ADDR_W-1:0] tgt_n;

    // An eret always overwrites; a branch overwrites anything but a held eret.
    always_comb begin
        kind_n = kind_q;
        tgt_n  = tgt_q;
        if (eret_req) begin
            kind_n = ERET;
            tgt_n  = epc;
        end else if (br_taken && (kind_q != ERET)) begin
            kind_n = BR;
            tgt_n  = br_target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kind_q <= NONE;
            tgt_q  <= '0;
        end else if (clear) begin
            kind_q <= NONE;
        end else if (capture) begin
            kind_q <= kind_n;
            tgt_q  <= tgt_n;
        end
    end

    assign merged_kind   = kind_n;
    assign merged_target = tgt_n;
    assign latched_kind  = kind_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch-address generator: PC register plus next-PC selection.
// Priority: exc_req > eret_req > br_taken > pc+STEP. Redirects arriving while
// en=0 are latched and applied on the first cycle with en=1.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   en            : 1 = advance PC, 0 = stall
//   br_taken,
//   br_target     : branch/jump redirect from D
//   eret_req, epc : return-from-exception request and return address
//   exc_req       : exception entry request (ignores en)
//   pc            : current fetch address (registered)
//   pc_valid      : pc is fetchable (low only during BOOT)
//   fetch_adel    : pc misaligned or outside [IMEM_LO, IMEM_HI]
//   redir_pending : a redirect is latched and waiting for en
module pc_gen
    import cpu_pkg::*;
#(
    parameter int unsigned              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]        RESET_PC = ADDR_W'(DEF_RESET_PC),
    parameter logic [ADDR_W-1:0]        EXC_PC   = ADDR_W'(DEF_EXC_PC),
    parameter logic [ADDR_W-1:0]        IMEM_LO  = ADDR_W'(DEF_IMEM_LO),
    parameter logic [ADDR_W-1:0]        IMEM_HI  = ADDR_W'(DEF_IMEM_HI),
    parameter int unsigned              STEP     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              eret_req,
    input  logic [ADDR_W-1:0] epc,
    input  logic              exc_req,
    output logic [ADDR_W-1:0] pc,
    output logic              pc_valid,
    output logic              fetch_adel,
    output logic              redir_pending
);

    pc_state_t         state;
    pc_state_t         state_n;
    logic [ADDR_W-1:0] pc_n;
    logic [1:0]        merged_kind;
    logic [ADDR_W-1:0] merged_target;
    logic [1:0]        latched_kind;
    logic              latch_clear;

    // Any edge with en=1 consumes the redirect; exception entry discards it.
    assign latch_clear = exc_req | en;

    pc_redir_latch #(
        .ADDR_W (ADDR_W)
    ) u_latch (
        .clk           (clk),
        .reset         (reset),
        .clear         (latch_clear),
        .capture       (~en),
        .eret_req      (eret_req),
        .epc           (epc),
        .br_taken      (br_taken),
        .br_target     (br_target),
        .merged_kind   (merged_kind),
        .merged_target (merged_target),
        .latched_kind  (latched_kind)
    );

    // The merged view already encodes the priority between live requests and
    // the stale latch, so an applied redirect is simply merged_target.
    always_comb begin
        pc_n    = pc;
        state_n = state;
        if (exc_req) begin
            pc_n    = EXC_PC;
            state_n = RUN;
        end else if (en) begin
            if (merged_kind != 2'(NONE)) begin
                pc_n = merged_target;
            end else begin
                pc_n = pc + ADDR_W'(STEP);
            end
            state_n = RUN;
        end else if (merged_kind != 2'(NONE)) begin
            state_n = HOLD;
        end else if (state == BOOT) begin
            state_n = RUN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BOOT;
            pc    <= RESET_PC;
        end else begin
            state <= state_n;
            pc    <= pc_n;
        end
    end

    assign pc_valid      = (state != BOOT);
    assign redir_pending = (state == HOLD) && (latched_kind != 2'(NONE));
    assign fetch_adel    = fetch_addr_err(64'(pc), 64'(IMEM_LO), 64'(IMEM_HI));

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

    logic        clk;
    logic        reset;
    logic        en;
    logic        br_taken;
    logic [31:0] br_target;
    logic        eret_req;
    logic [31:0] epc;
    logic        exc_req;
    logic [31:0] pc;
    logic        pc_valid;
    logic        fetch_adel;
    logic        redir_pending;

    int unsigned total;
    int unsigned passed;

    // Reference model state: what the fetch unit should look like
    logic [31:0] m_pc;
    logic        m_valid;
    int          m_kind;   // 0 nothing pending, 1 branch, 2 eret
    logic [31:0] m_tgt;

    pc_gen #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_3000),
        .EXC_PC   (32'h0000_4180),
        .IMEM_LO  (32'h0000_3000),
        .IMEM_HI  (32'h0000_6FFC),
        .STEP     (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .br_taken      (br_taken),
        .br_target     (br_target),
        .eret_req      (eret_req),
        .epc           (epc),
        .exc_req       (exc_req),
        .pc            (pc),
        .pc_valid      (pc_valid),
        .fetch_adel    (fetch_adel),
        .redir_pending (redir_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic exp_adel(input logic [31:0] a);
        return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6FFC);
    endfunction

    task automatic model_reset();
        m_pc    = 32'h0000_3000;
        m_valid = 1'b0;
        m_kind  = 0;
        m_tgt   = '0;
    endtask

    task automatic model_step();
        int          k;
        logic [31:0] t;
        if (exc_req) begin
            m_pc   = 32'h0000_4180;
            m_kind = 0;
        end else begin
            k = m_kind;
            t = m_tgt;
            if (eret_req) begin
                k = 2;
                t = epc;
            end else if (br_taken && k != 2) begin
                k = 1;
                t = br_target;
            end
            if (en) begin
                m_pc   = (k != 0) ? t : m_pc + 32'd4;
                m_kind = 0;
            end else begin
                m_kind = k;
                m_tgt  = t;
            end
        end
        m_valid = 1'b1;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"}, pc, m_pc);
        check({tag, ".valid"}, 32'(pc_valid), 32'(m_valid));
        check({tag, ".pend"}, 32'(redir_pending), 32'(m_kind != 0));
        check({tag, ".adel"}, 32'(fetch_adel), 32'(exp_adel(m_pc)));
    endtask

    task automatic drive(input logic e, input logic b, input logic [31:0] bt,
                         input logic r, input logic [31:0] ep, input logic x,
                         input string tag);
        en        = e;
        br_taken  = b;
        br_target = bt;
        eret_req  = r;
        epc       = ep;
        exc_req   = x;
        @(posedge clk);
        #1;
        model_step();
        check_all(tag);
    endtask

    initial begin
        logic [31:0] t;
        total  = 0;
        passed = 0;
        reset = 1'b1; en = 1'b0; br_taken = 1'b0; br_target = '0;
        eret_req = 1'b0; epc = '0; exc_req = 1'b0;
        model_reset();
        #2;
        check_all("reset");
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check_all("boot");
        check("boot_pc", pc, 32'h3000);
        check("boot_valid", 32'(pc_valid), 32'd0);

        drive(1, 0, 0, 0, 0, 0, "first_step");
        check("first_pc", pc, 32'h3004);

        // branch with en=1
        drive(1, 1, 32'h3100, 0, 0, 0, "br");
        check("br_pc", pc, 32'h3100);
        drive(1, 0, 0, 0, 0, 0, "br_next");
        check("br_next_pc", pc, 32'h3104);

        // branch during a stall
        drive(0, 1, 32'h3200, 0, 0, 0, "stall_br");
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, "stall_hold");
        check("stall_pend", 32'(redir_pending), 32'd1);
        drive(1, 0, 0, 0, 0, 0, "stall_rel");
        check("stall_rel_pc", pc, 32'h3200);
        check("stall_rel_pend", 32'(redir_pending), 32'd0);

        // exception discards latched branch
        drive(0, 1, 32'h3200, 0, 0, 0, "exc_latch");
        drive(0, 0, 0, 0, 0, 1, "exc");
        check("exc_pc", pc, 32'h4180);
        drive(1, 0, 0, 0, 0, 0, "exc_next");
        check("exc_next_pc", pc, 32'h4184);
        drive(1, 0, 0, 0, 0, 0, "exc_next2");

        // eret beats branch, live and latched
        drive(1, 1, 32'h3300, 1, 32'h3010, 0, "eret_live");
        check("eret_live_pc", pc, 32'h3010);
        drive(1, 0, 0, 0, 0, 0, "eret_step");
        drive(0, 1, 32'h3300, 1, 32'h3010, 0, "eret_latch");
        drive(0, 1, 32'h3400, 0, 0, 0, "eret_keep");
        drive(1, 0, 0, 0, 0, 0, "eret_rel");
        check("eret_rel_pc", pc, 32'h3010);

        // live branch beats a stale latched branch
        drive(0, 1, 32'h3500, 0, 0, 0, "stale_br");
        drive(1, 1, 32'h3600, 0, 0, 0, "live_br");
        check("live_br_pc", pc, 32'h3600);

        // address error boundaries and wrap
        drive(1, 1, 32'h3002, 0, 0, 0, "adel_mis");
        check("adel_mis", 32'(fetch_adel), 32'd1);
        drive(1, 1, 32'h7000, 0, 0, 0, "adel_hi");
        check("adel_hi", 32'(fetch_adel), 32'd1);
        drive(1, 1, 32'h6FFC, 0, 0, 0, "adel_top");
        check("adel_top", 32'(fetch_adel), 32'd0);
        drive(1, 1, 32'h2FFC, 0, 0, 0, "adel_lo");
        drive(1, 1, 32'hFFFF_FFFC, 0, 0, 0, "wrap_pre");
        drive(1, 0, 0, 0, 0, 0, "wrap");
        check("wrap_pc", pc, 32'h0);

        // asynchronous reset while a redirect is latched
        drive(0, 1, 32'h3700, 0, 0, 0, "rst_hold");
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check_all("reboot");
        drive(1, 0, 0, 0, 0, 0, "reboot_step");

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            t = 32'h2000 + {$urandom_range(0, 32'h1FFF), 2'b00};
            if ($urandom_range(0, 9) == 0) t[1:0] = 2'($urandom);
            drive(($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 3) == 0), t,
                  ($urandom_range(0, 9) == 0), 32'h3000 + {$urandom_range(0, 32'hFFF), 2'b00},
                  ($urandom_range(0, 19) == 0), "rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
